// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU pipeline.
//   state_t         - memory-access FSM state encoding (IDLE, BUSY, DONE)
//   TIMEOUT_DEFAULT - default number of cycles to wait for a data-memory ack
//   cnt_width()     - bit width needed to hold a count from 0 up to a limit
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wdog_counter.sv
// wdog_counter: watchdog cycle counter for a bus transaction.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear (wins over en)
//   en          - count this cycle
//   count [W]   - current count
//   expired     - high on the LIMIT-th enabled cycle since the last clear
module wdog_counter #(
    parameter int LIMIT = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         expired
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

    // Count starts at 0 in the first cycle, so LIMIT-1 marks the last allowed cycle.
    assign expired = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage. Issues aligned loads/stores on the data
// bus, freezes the front of the pipeline while waiting for ack, and registers
// the write-back fields.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   mem_* inputs                   - EX/MEM register contents
//   dmem_req/we/addr/wdata (out)   - data-memory request, held stable while BUSY
//   dmem_ack/rdata (in)            - data-memory response, only sampled while BUSY
//   mem_stall                      - freeze IF..EX/MEM
//   wb_RegWrite/RegisterRd/data    - registered write-back
//   mem_err                        - one-cycle pulse on misalignment or timeout
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic        mem_MemtoReg,
    input  logic        mem_RegWrite,
    input  logic        mem_call,
    input  logic [4:0]  mem_RegisterRd,
    input  logic [31:0] mem_ALUOUT,
    input  logic [31:0] mem_RFRD2,
    input  logic [31:0] mem_pcplus4,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_RegisterRd,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam int CW = cnt_width(TIMEOUT);

    state_t        state, state_nx;
    logic          access, is_store, misal, start, misal_acc, timeout_hit;
    logic          stall_c, wb_load, wb_fault, we_q, fault_q, expired;
    logic [31:0]   rdata_q;
    logic [CW-1:0] cnt;

    // Read wins when both strobes are set, so a store is write-without-read.
    assign access      = mem_MemRead | mem_MemWrite;
    assign is_store    = mem_MemWrite & ~mem_MemRead;
    assign misal       = |mem_ALUOUT[1:0];
    assign start       = (state == IDLE) && access && !misal;
    assign misal_acc   = (state == IDLE) && access && misal;
    assign timeout_hit = (state == BUSY) && !dmem_ack && expired;

    wdog_counter #(
        .LIMIT (TIMEOUT),
        .W     (CW)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .en      (state == BUSY),
        .count   (cnt),
        .expired (expired)
    );

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        case (state)
            IDLE: begin
                stall_c = start;
                if (start)
                    state_nx = BUSY;
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem_ack || expired)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stall must not leak out while the unit is held in reset.
    assign mem_stall = rst_n & stall_c;
    assign dmem_req  = (state == BUSY);
    assign dmem_we   = (state == BUSY) & we_q;

    // Write-back loads on every instruction that leaves the stage this cycle.
    assign wb_load  = ((state == IDLE) && !start) || (state == DONE);
    assign wb_fault = misal_acc || ((state == DONE) && fault_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            we_q       <= 1'b0;
        end else if (start) begin
            dmem_addr  <= mem_ALUOUT;
            dmem_wdata <= mem_RFRD2;
            we_q       <= is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            fault_q <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= misal_acc | timeout_hit;
            if (start)
                fault_q <= 1'b0;
            else if (timeout_hit)
                fault_q <= 1'b1;
            if ((state == BUSY) && dmem_ack)
                rdata_q <= dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_RegWrite   <= 1'b0;
            wb_RegisterRd <= '0;
            wb_data       <= '0;
        end else if (wb_load) begin
            // A store never writes a register unless it is a call.
            wb_RegWrite   <= mem_RegWrite && (mem_RegisterRd != 5'd0) && !wb_fault
                             && (!is_store || mem_call);
            wb_RegisterRd <= mem_RegisterRd;
            wb_data       <= mem_call ? mem_pcplus4 : mem_MemtoReg ? rdata_q : mem_ALUOUT;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a per-cycle expectation schedule
// computed from the transaction rules, plus literal spot checks.
module tb_mem_access_unit;

    localparam int TO   = 8;
    localparam int MAXC = 1024;

    typedef struct packed {
        logic        mr, mw, m2r, rw, call;
        logic [4:0]  rd;
        logic [31:0] alu, st, pc4;
    } instr_t;

    logic        clk, rst_n;
    logic        mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite, mem_call;
    logic [4:0]  mem_RegisterRd;
    logic [31:0] mem_ALUOUT, mem_RFRD2, mem_pcplus4;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall, wb_RegWrite, mem_err;
    logic [4:0]  wb_RegisterRd;
    logic [31:0] wb_data;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_MemRead    (mem_MemRead),
        .mem_MemWrite   (mem_MemWrite),
        .mem_MemtoReg   (mem_MemtoReg),
        .mem_RegWrite   (mem_RegWrite),
        .mem_call       (mem_call),
        .mem_RegisterRd (mem_RegisterRd),
        .mem_ALUOUT     (mem_ALUOUT),
        .mem_RFRD2      (mem_RFRD2),
        .mem_pcplus4    (mem_pcplus4),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .wb_RegWrite    (wb_RegWrite),
        .wb_RegisterRd  (wb_RegisterRd),
        .wb_data        (wb_data),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected values per cycle index.
    bit          e_stall [MAXC];
    bit          e_req   [MAXC];
    bit          e_err   [MAXC];
    bit          e_we    [MAXC];
    bit          e_wbwe  [MAXC];
    logic [4:0]  e_rd    [MAXC];
    logic [31:0] e_addr  [MAXC];
    logic [31:0] e_wdata [MAXC];
    logic [31:0] e_data  [MAXC];

    int checks = 0, fails = 0;
    int n_stall = 0, n_req = 0, n_err = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("mem_stall", 32'(mem_stall), 32'(e_stall[cyc]));
            chk("dmem_req", 32'(dmem_req), 32'(e_req[cyc]));
            chk("mem_err", 32'(mem_err), 32'(e_err[cyc]));
            if (e_req[cyc]) begin
                chk("dmem_we", 32'(dmem_we), 32'(e_we[cyc]));
                chk("dmem_addr", dmem_addr, e_addr[cyc]);
                chk("dmem_wdata", dmem_wdata, e_wdata[cyc]);
            end
            chk("wb_RegWrite", 32'(wb_RegWrite), 32'(e_wbwe[cyc]));
            chk("wb_RegisterRd", 32'(wb_RegisterRd), 32'(e_rd[cyc]));
            chk("wb_data", wb_data, e_data[cyc]);
        end
        n_stall += int'(mem_stall);
        n_req   += int'(dmem_req);
        n_err   += int'(mem_err);
    end

    function automatic instr_t mk(input bit mr, mw, m2r, rw, call, input logic [4:0] rd,
                                  input logic [31:0] alu, st, pc4);
        instr_t t;
        t.mr = mr; t.mw = mw; t.m2r = m2r; t.rw = rw; t.call = call;
        t.rd = rd; t.alu = alu; t.st = st; t.pc4 = pc4;
        return t;
    endfunction

    task automatic drive(input instr_t in);
        mem_MemRead    = in.mr;
        mem_MemWrite   = in.mw;
        mem_MemtoReg   = in.m2r;
        mem_RegWrite   = in.rw;
        mem_call       = in.call;
        mem_RegisterRd = in.rd;
        mem_ALUOUT     = in.alu;
        mem_RFRD2      = in.st;
        mem_pcplus4    = in.pc4;
    endtask

    task automatic wb_from(input int c, input bit we, input logic [4:0] rd, input logic [31:0] d);
        for (int j = c; j < MAXC; j++) begin
            e_wbwe[j] = we;
            e_rd[j]   = rd;
            e_data[j] = d;
        end
    endtask

    // Plans the schedule of one instruction, then drives it while the pipeline
    // holds it. ack_k = BUSY cycle (1-based) carrying the ack, 0 = never acked.
    // Called at #1 after a rising edge; returns at #1 after the edge that retires it.
    task automatic issue(input instr_t in, input int ack_k, input logic [31:0] rdata, input bit stray);
        int c0 = cyc;
        bit acc = in.mr | in.mw;
        bit mis = acc && (in.alu[1:0] != 2'b00);
        bit go = acc && !mis;
        int b = go ? ((ack_k > 0) ? ack_k : TO) : 0;
        int l = go ? b + 2 : 1;
        bit fault = mis || (go && ack_k == 0);
        bit store = in.mw && !in.mr;
        if (go && ack_k > 0)
            model_rdata = rdata;
        for (int i = 0; i < l; i++) begin
            e_stall[c0 + i] = go && (i < l - 1);
            e_req[c0 + i]   = go && (i >= 1) && (i <= b);
            e_we[c0 + i]    = store;
            e_addr[c0 + i]  = in.alu;
            e_wdata[c0 + i] = in.st;
        end
        if (mis)
            e_err[c0 + 1] = 1'b1;
        if (go && ack_k == 0)
            e_err[c0 + b + 1] = 1'b1;
        wb_from(c0 + l, in.rw && (in.rd != 5'd0) && !fault && (!store || in.call), in.rd,
                in.call ? in.pc4 : in.m2r ? model_rdata : in.alu);
        drive(in);
        for (int i = 0; i < l; i++) begin
            dmem_ack   = (go && ack_k > 0 && i == ack_k) || (stray && i == 0);
            dmem_rdata = (go && i == ack_k) ? rdata : 32'hBAD0BAD0;
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b0;
    endtask

    instr_t nop, ld;
    int s0, r0, e0;

    initial begin
        for (int j = 0; j < MAXC; j++) begin
            e_stall[j] = 0; e_req[j] = 0; e_err[j] = 0; e_we[j] = 0; e_wbwe[j] = 0;
            e_rd[j] = '0; e_addr[j] = '0; e_wdata[j] = '0; e_data[j] = '0;
        end
        nop = mk(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(nop);
        #1;
        chk("reset_wb_data", wb_data, 32'h0);
        chk("reset_dmem_req", 32'(dmem_req), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU result, then the same with Rd=0.
        issue(mk(0, 0, 0, 1, 0, 5'd3, 32'h42, 32'h0, 32'h0), 0, 32'h0, 0);
        chk("alu_wb_data", wb_data, 32'h42);
        chk("alu_wb_we", 32'(wb_RegWrite), 32'h1);
        issue(mk(0, 0, 0, 1, 0, 5'd0, 32'h43, 32'h0, 32'h0), 0, 32'h0, 0);
        chk("alu_rd0_wb_we", 32'(wb_RegWrite), 32'h0);

        // Load acked in the first BUSY cycle.
        s0 = n_stall;
        issue(mk(1, 0, 1, 1, 0, 5'd5, 32'h100, 32'h0, 32'h0), 1, 32'hDEADBEEF, 0);
        chk("load_stall_cycles", 32'(n_stall - s0), 32'd2);
        chk("load_wb_data", wb_data, 32'hDEADBEEF);
        chk("load_wb_rd", 32'(wb_RegisterRd), 32'd5);
        chk("load_wb_we", 32'(wb_RegWrite), 32'h1);

        // Store acked in the fourth BUSY cycle; RegWrite set but must not write back.
        r0 = n_req;
        issue(mk(0, 1, 0, 1, 0, 5'd9, 32'h200, 32'h12345678, 32'h0), 4, 32'h0, 0);
        chk("store_req_cycles", 32'(n_req - r0), 32'd4);
        chk("store_wb_we", 32'(wb_RegWrite), 32'h0);

        // Call, then a store that is also a call.
        issue(mk(0, 0, 0, 1, 1, 5'd31, 32'h55, 32'h0, 32'h1004), 0, 32'h0, 0);
        chk("call_wb_data", wb_data, 32'h1004);
        chk("call_wb_we", 32'(wb_RegWrite), 32'h1);
        issue(mk(0, 1, 0, 1, 1, 5'd31, 32'h204, 32'hA5A5A5A5, 32'h2008), 2, 32'h0, 0);
        chk("store_call_wb_we", 32'(wb_RegWrite), 32'h1);

        // Read and write both set: read wins.
        issue(mk(1, 1, 1, 1, 0, 5'd6, 32'h108, 32'h11111111, 32'h0), 1, 32'hCAFEF00D, 0);
        chk("rdwr_wb_data", wb_data, 32'hCAFEF00D);

        // Ack outside BUSY must not disturb the captured read data.
        issue(mk(0, 0, 0, 1, 0, 5'd4, 32'h77, 32'h0, 32'h0), 0, 32'h0, 1);
        issue(mk(0, 0, 1, 1, 0, 5'd8, 32'h78, 32'h0, 32'h0), 0, 32'h0, 0);
        chk("stray_ack_wb_data", wb_data, 32'hCAFEF00D);

        // Misaligned load.
        r0 = n_req;
        issue(mk(1, 0, 1, 1, 0, 5'd5, 32'h102, 32'h0, 32'h0), 1, 32'h0, 0);
        chk("misal_err", 32'(mem_err), 32'h1);
        chk("misal_wb_we", 32'(wb_RegWrite), 32'h0);
        issue(nop, 0, 32'h0, 0);
        chk("misal_req_cycles", 32'(n_req - r0), 32'd0);

        // Load never acked: times out after TO cycles.
        r0 = n_req;
        e0 = n_err;
        issue(mk(1, 0, 1, 1, 0, 5'd10, 32'h104, 32'h0, 32'h0), 0, 32'h0, 0);
        chk("timeout_req_cycles", 32'(n_req - r0), 32'd8);
        chk("timeout_err_pulses", 32'(n_err - e0), 32'd1);
        chk("timeout_wb_we", 32'(wb_RegWrite), 32'h0);
        issue(nop, 0, 32'h0, 0);

        // Reset asserted in the middle of a BUSY transaction.
        ld = mk(1, 0, 1, 1, 0, 5'd7, 32'h300, 32'h0, 32'h0);
        e_stall[cyc] = 1'b1;
        drive(ld);
        @(posedge clk);
        #1;
        chk("busy_req_before_reset", 32'(dmem_req), 32'h1);
        for (int j = cyc; j < MAXC; j++) begin
            e_stall[j] = 0; e_req[j] = 0; e_err[j] = 0;
        end
        wb_from(cyc, 1'b0, 5'd0, 32'h0);
        model_rdata = 32'h0;
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        drive(nop);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(nop, 0, 32'h0, 0);
        issue(nop, 0, 32'h0, 0);
        chk("post_reset_wb_we", 32'(wb_RegWrite), 32'h0);

        // Misaligned store after reset.
        issue(mk(0, 1, 0, 0, 0, 5'd2, 32'h201, 32'h9, 32'h0), 0, 32'h0, 0);
        issue(nop, 0, 32'h0, 0);
        issue(nop, 0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
